// File: rtl/alu_operand_stage.sv
// ALU operand stage: forwards in-flight results onto rs1/rs2, selects the A/B
// operands by RV32I opcode and holds them in a two-entry valid/ready skid buffer.
module alu_operand_stage #(
    parameter int XLEN    = 32,
    parameter int REG_AW  = 5,
    parameter int NUM_FWD = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [6:0]                opcode,
    input  logic [REG_AW-1:0]         rs1_addr,
    input  logic [REG_AW-1:0]         rs2_addr,
    input  logic [XLEN-1:0]           rs1_data,
    input  logic [XLEN-1:0]           rs2_data,
    input  logic [XLEN-1:0]           imm,
    input  logic [XLEN-1:0]           pc,
    input  logic [NUM_FWD-1:0]        fwd_valid,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_addr,
    input  logic [NUM_FWD*XLEN-1:0]   fwd_data,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [XLEN-1:0]           alu_a,
    output logic [XLEN-1:0]           alu_b,
    output logic [6:0]                out_opcode,
    output logic                      out_illegal
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [XLEN-1:0]   XZERO = {XLEN{1'b0}};
    localparam logic [XLEN-1:0]   LUI_SHAMT = {{(XLEN-4){1'b0}}, 4'd12};
    localparam logic [REG_AW-1:0] RZERO = {REG_AW{1'b0}};

    logic [XLEN-1:0] rs1_eff_s, rs2_eff_s;
    logic            rs1_hit_s, rs2_hit_s;
    logic [XLEN-1:0] new_a_s, new_b_s;
    logic            new_ill_s;

    logic            accept_s, drain_s;
    logic            out_load_s, out_from_skid_s, skid_load_s;
    logic            out_vld_d, skid_vld_d;

    logic            out_vld_q, skid_vld_q, in_rdy_q;
    logic [XLEN-1:0] out_a_q, out_b_q, skid_a_q, skid_b_q;
    logic [6:0]      out_opc_q, skid_opc_q;
    logic            out_ill_q, skid_ill_q;

    // Forwarding: lowest-index (youngest) matching source wins; x0 never forwards.
    always_comb begin
        rs1_eff_s = rs1_data;
        rs2_eff_s = rs2_data;
        rs1_hit_s = 1'b0;
        rs2_hit_s = 1'b0;
        for (int i = 0; i < NUM_FWD; i++) begin
            if (!rs1_hit_s && fwd_valid[i] && (rs1_addr != RZERO) &&
                (fwd_addr[i*REG_AW +: REG_AW] == rs1_addr)) begin
                rs1_eff_s = fwd_data[i*XLEN +: XLEN];
                rs1_hit_s = 1'b1;
            end else begin
                rs1_hit_s = rs1_hit_s;
            end
            if (!rs2_hit_s && fwd_valid[i] && (rs2_addr != RZERO) &&
                (fwd_addr[i*REG_AW +: REG_AW] == rs2_addr)) begin
                rs2_eff_s = fwd_data[i*XLEN +: XLEN];
                rs2_hit_s = 1'b1;
            end else begin
                rs2_hit_s = rs2_hit_s;
            end
        end
    end

    // Operand selection by major opcode; unknown opcodes flow through flagged illegal.
    always_comb begin
        new_a_s   = XZERO;
        new_b_s   = XZERO;
        new_ill_s = 1'b0;
        case (opcode)
            OP_R: begin
                new_a_s = rs1_eff_s;
                new_b_s = rs2_eff_s;
            end
            OP_I, OP_LOAD, OP_JALR, OP_STORE: begin
                new_a_s = rs1_eff_s;
                new_b_s = imm;
            end
            OP_JAL, OP_BRANCH: begin
                new_a_s = pc;
                new_b_s = imm;
            end
            OP_LUI: begin
                new_a_s = imm;
                new_b_s = LUI_SHAMT;
            end
            OP_AUIPC: begin
                new_a_s = imm;
                new_b_s = pc;
            end
            default: begin
                new_ill_s = 1'b1;
            end
        endcase
    end

    // Skid-buffer control: OUT drains first, SKID refills OUT, new entries land behind.
    always_comb begin
        accept_s        = in_valid && in_rdy_q && !flush;
        drain_s         = out_vld_q && out_ready;
        out_vld_d       = out_vld_q;
        skid_vld_d      = skid_vld_q;
        out_load_s      = 1'b0;
        out_from_skid_s = 1'b0;
        skid_load_s     = 1'b0;
        if (flush) begin
            out_vld_d  = 1'b0;
            skid_vld_d = 1'b0;
        end else if (!out_vld_q || drain_s) begin
            if (skid_vld_q) begin
                out_load_s      = 1'b1;
                out_from_skid_s = 1'b1;
                out_vld_d       = 1'b1;
                skid_load_s     = accept_s;
                skid_vld_d      = accept_s;
            end else begin
                out_load_s = accept_s;
                out_vld_d  = accept_s;
            end
        end else begin
            if (accept_s) begin
                skid_load_s = 1'b1;
                skid_vld_d  = 1'b1;
            end else begin
                skid_vld_d = skid_vld_q;
            end
        end
    end

    // Valid bits and registered ready, derived from next-state SKID occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q  <= 1'b0;
            skid_vld_q <= 1'b0;
            in_rdy_q   <= 1'b1;
        end else begin
            out_vld_q  <= out_vld_d;
            skid_vld_q <= skid_vld_d;
            in_rdy_q   <= !skid_vld_d;
        end
    end

    // Data registers load only on capture so held outputs stay stable under stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_a_q    <= XZERO;
            out_b_q    <= XZERO;
            out_opc_q  <= 7'd0;
            out_ill_q  <= 1'b0;
            skid_a_q   <= XZERO;
            skid_b_q   <= XZERO;
            skid_opc_q <= 7'd0;
            skid_ill_q <= 1'b0;
        end else begin
            if (out_load_s) begin
                if (out_from_skid_s) begin
                    out_a_q   <= skid_a_q;
                    out_b_q   <= skid_b_q;
                    out_opc_q <= skid_opc_q;
                    out_ill_q <= skid_ill_q;
                end else begin
                    out_a_q   <= new_a_s;
                    out_b_q   <= new_b_s;
                    out_opc_q <= opcode;
                    out_ill_q <= new_ill_s;
                end
            end
            if (skid_load_s) begin
                skid_a_q   <= new_a_s;
                skid_b_q   <= new_b_s;
                skid_opc_q <= opcode;
                skid_ill_q <= new_ill_s;
            end
        end
    end

    assign in_ready    = in_rdy_q;
    assign out_valid   = out_vld_q;
    assign alu_a       = out_a_q;
    assign alu_b       = out_b_q;
    assign out_opcode  = out_opc_q;
    assign out_illegal = out_ill_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the operand rules and FIFO occupancy.
module tb_alu_operand_stage;

    localparam int XLEN = 32;
    localparam int REG_AW = 5;
    localparam int NUM_FWD = 2;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [6:0]  opc;
        logic        ill;
    } entry_t;

    logic        clk, rst_n;
    logic        in_valid, in_ready, flush, out_valid, out_ready, out_illegal;
    logic [6:0]  opcode, out_opcode;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data, imm, pc, alu_a, alu_b;
    logic        fv [NUM_FWD];
    logic [4:0]  fa [NUM_FWD];
    logic [31:0] fd [NUM_FWD];
    logic [NUM_FWD-1:0]        fwd_valid;
    logic [NUM_FWD*REG_AW-1:0] fwd_addr;
    logic [NUM_FWD*XLEN-1:0]   fwd_data;

    assign fwd_valid = {fv[1], fv[0]};
    assign fwd_addr  = {fa[1], fa[0]};
    assign fwd_data  = {fd[1], fd[0]};

    alu_operand_stage #(.XLEN(XLEN), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .pc(pc),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .out_opcode(out_opcode), .out_illegal(out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     n_checks = 0;
    int     n_pass = 0;
    entry_t mq[$];
    bit     last_acc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic logic [31:0] eff(input logic [4:0] addr, input logic [31:0] data);
        if (addr == 5'd0) return data;
        for (int i = 0; i < NUM_FWD; i++)
            if (fv[i] && fa[i] == addr) return fd[i];
        return data;
    endfunction

    function automatic entry_t ref_entry();
        entry_t e;
        logic [31:0] r1, r2;
        r1 = eff(rs1_addr, rs1_data);
        r2 = eff(rs2_addr, rs2_data);
        e.opc = opcode;
        e.ill = 1'b0;
        case (opcode)
            7'b0110011: begin e.a = r1; e.b = r2; end
            7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011: begin e.a = r1; e.b = imm; end
            7'b1101111, 7'b1100011: begin e.a = pc; e.b = imm; end
            7'b0110111: begin e.a = imm; e.b = 32'd12; end
            7'b0010111: begin e.a = imm; e.b = pc; end
            default: begin e.a = 32'd0; e.b = 32'd0; e.ill = 1'b1; end
        endcase
        return e;
    endfunction

    task automatic check_model();
        chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
        chk("in_ready", 64'(in_ready), 64'(mq.size() < 2));
        if (mq.size() != 0) begin
            chk("alu_a", 64'(alu_a), 64'(mq[0].a));
            chk("alu_b", 64'(alu_b), 64'(mq[0].b));
            chk("out_opcode", 64'(out_opcode), 64'(mq[0].opc));
            chk("out_illegal", 64'(out_illegal), 64'(mq[0].ill));
        end
    endtask

    // Inputs are set at a negedge; advance one clock, update the model, check at next negedge.
    task automatic step();
        entry_t e;
        bit acc, drn;
        e   = ref_entry();
        acc = in_valid && (mq.size() < 2) && !flush;
        drn = (mq.size() != 0) && out_ready;
        @(posedge clk);
        if (drn) void'(mq.pop_front());
        if (flush) mq.delete();
        else if (acc) mq.push_back(e);
        last_acc = acc;
        @(negedge clk);
        check_model();
    endtask

    task automatic clear_inputs();
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        opcode = 7'b0110011; rs1_addr = 5'd0; rs2_addr = 5'd0;
        rs1_data = 32'd0; rs2_data = 32'd0; imm = 32'd0; pc = 32'd0;
        for (int i = 0; i < NUM_FWD; i++) begin fv[i] = 1'b0; fa[i] = 5'd0; fd[i] = 32'd0; end
    endtask

    task automatic rand_inputs();
        logic [6:0] ops [10];
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
                7'b1101111, 7'b1100011, 7'b0110111, 7'b0010111, 7'b1111111};
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 9) < 6);
        flush     = ($urandom_range(0, 19) == 0);
        opcode    = ($urandom_range(0, 7) == 0) ? 7'($urandom) : ops[$urandom_range(0, 9)];
        rs1_addr  = 5'($urandom_range(0, 7));
        rs2_addr  = 5'($urandom_range(0, 7));
        rs1_data  = $urandom; rs2_data = $urandom; imm = $urandom; pc = $urandom;
        for (int i = 0; i < NUM_FWD; i++) begin
            fv[i] = 1'($urandom); fa[i] = 5'($urandom_range(0, 7)); fd[i] = $urandom;
        end
    endtask

    initial begin
        logic [31:0] got[$];
        int k;
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst in_ready", 64'(in_ready), 64'd1);
        chk("rst alu_a", 64'(alu_a), 64'd0);
        chk("rst alu_b", 64'(alu_b), 64'd0);
        chk("rst out_opcode", 64'(out_opcode), 64'd0);
        chk("rst out_illegal", 64'(out_illegal), 64'd0);
        rst_n = 1'b1;

        // R-type, latency one cycle
        in_valid = 1'b1; opcode = 7'b0110011; rs1_addr = 5'd1; rs2_addr = 5'd2;
        rs1_data = 32'd5; rs2_data = 32'd7;
        step();
        chk("R out_valid", 64'(out_valid), 64'd1);
        chk("R a", 64'(alu_a), 64'd5);
        chk("R b", 64'(alu_b), 64'd7);
        chk("R opcode", 64'(out_opcode), 64'h33);

        // Forwarding priority and x0
        opcode = 7'b0010011; rs1_addr = 5'd3; rs1_data = 32'h1111;
        fv[0] = 1'b1; fa[0] = 5'd3; fd[0] = 32'hAAAA;
        fv[1] = 1'b1; fa[1] = 5'd3; fd[1] = 32'hBBBB;
        step();
        chk("fwd prio a", 64'(alu_a), 64'hAAAA);
        rs1_addr = 5'd0; fa[0] = 5'd0; fa[1] = 5'd0; rs1_data = 32'h1234;
        step();
        chk("fwd x0 a", 64'(alu_a), 64'h1234);
        fv[0] = 1'b0; fv[1] = 1'b0;

        opcode = 7'b1101111; pc = 32'h100; imm = 32'h20;
        step();
        chk("JAL a", 64'(alu_a), 64'h100);
        chk("JAL b", 64'(alu_b), 64'h20);
        opcode = 7'b0110111; imm = 32'h12345;
        step();
        chk("LUI a", 64'(alu_a), 64'h12345);
        chk("LUI b", 64'(alu_b), 64'd12);
        opcode = 7'b0010111; imm = 32'h5000; pc = 32'h240;
        step();
        chk("AUIPC a", 64'(alu_a), 64'h5000);
        chk("AUIPC b", 64'(alu_b), 64'h240);
        opcode = 7'b1111111;
        step();
        chk("ILL a", 64'(alu_a), 64'd0);
        chk("ILL b", 64'(alu_b), 64'd0);
        chk("ILL flag", 64'(out_illegal), 64'd1);

        // Backpressure: two entries absorbed, then ordered delivery
        clear_inputs();
        repeat (2) step();
        k = 1; out_ready = 1'b0;
        for (int cyc = 0; cyc < 40 && got.size() < 4; cyc++) begin
            if (cyc == 2) begin
                chk("bp in_ready", 64'(in_ready), 64'd0);
                chk("bp held a", 64'(alu_a), 64'd1);
            end
            if (cyc >= 4) out_ready = 1'b1;
            if (out_valid && out_ready) got.push_back(alu_a);
            in_valid = (k <= 4); rs1_data = 32'(k); rs1_addr = 5'd1; opcode = 7'b0110011;
            step();
            if (last_acc) k++;
        end
        chk("bp count", 64'(got.size()), 64'd4);
        for (int i = 0; i < got.size(); i++) chk("bp order", 64'(got[i]), 64'(i + 1));

        // Flush with both registers full
        clear_inputs();
        repeat (2) step();
        out_ready = 1'b0; in_valid = 1'b1; rs1_data = 32'h42;
        repeat (2) step();
        chk("fl full", 64'(in_ready), 64'd0);
        flush = 1'b1; rs1_data = 32'h99;
        step();
        chk("fl out_valid", 64'(out_valid), 64'd0);
        chk("fl in_ready", 64'(in_ready), 64'd1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) begin
            step();
            chk("fl dropped", 64'(out_valid), 64'd0);
        end

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            rand_inputs();
            step();
        end

        // Asynchronous reset between edges
        clear_inputs();
        out_ready = 1'b0; in_valid = 1'b1; opcode = 7'b0010011; rs1_data = 32'hDEAD;
        imm = 32'hBEEF; rs1_addr = 5'd4;
        repeat (2) step();
        #2 rst_n = 1'b0;
        #1;
        chk("arst out_valid", 64'(out_valid), 64'd0);
        chk("arst in_ready", 64'(in_ready), 64'd1);
        chk("arst alu_a", 64'(alu_a), 64'd0);
        chk("arst alu_b", 64'(alu_b), 64'd0);
        mq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
